fetch_sequencer: RTL

Fetch sequencer sitting between the 256-byte instruction memory and the decode stage. It owns the program counter, issues addresses to the memory's registered 16-bit read port, presents each fetched instruction through a valid/ready handshake, applies branch redirects, and stops at a HALT word. Optionally it also owns the memory's byte write port for program loading while the core is idle.

---
 rtl/fetch_sequencer_pkg.sv | 23 ++
 rtl/fetch_pc_reg.sv | 24 ++
 rtl/fetch_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer and its pc register.
package fetch_sequencer_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0]  PC_STEP           = 8'd2;
    localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 16'h0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_VALID,
        S_HALTED
    } fetch_state_e;

    // Instructions are halfword aligned; address bit 0 never reaches the pc.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset load, redirect load (priority) and +PC_STEP increment.
module fetch_pc_reg
    import fetch_sequencer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pc <= align_pc(RESET_PC);
        else if (load)
            pc <= align_pc(load_pc);
        else if (inc)
            pc <= pc + PC_STEP;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: pc ownership, registered-memory fetch, valid/ready delivery, redirect, HALT.
// Define FETCH_LOADER_EN to add the idle-time byte loader on the memory write port.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = 8'h00,
    parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
`ifdef FETCH_LOADER_EN
    ,
    input  logic               ld_valid,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [7:0]         ld_data,
    output logic               ld_ready,
    output logic               mem_we,
    output logic [7:0]         mem_wdata
`endif
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic              pc_inc;

    assign pc_inc = (state == S_VALID) && instr_ready && !redirect_valid
                    && (instr != HALT_WORD);

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .inc     (pc_inc),
        .pc      (pc)
    );

    // Redirect overrides every state; the WAIT capture is skipped so a stale word never shows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (redirect_valid) begin
            state       <= S_ISSUE;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                S_IDLE:   if (fetch_en) state <= S_ISSUE;
                S_ISSUE:  state <= S_WAIT;
                S_WAIT: begin
                    instr       <= mem_rdata;
                    instr_pc    <= pc;
                    instr_valid <= 1'b1;
                    state       <= S_VALID;
                end
                S_VALID: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (instr == HALT_WORD) begin
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end else begin
                            state  <= S_ISSUE;
                        end
                    end
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_IDLE;
            endcase
        end
    end

`ifdef FETCH_LOADER_EN
    logic ld_arm;

    // Keeps ld_ready low while reset is held and for the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ld_arm <= 1'b0;
        else
            ld_arm <= 1'b1;
    end

    assign ld_ready  = ld_arm && !redirect_valid
                       && (state == S_IDLE || state == S_HALTED);
    assign mem_we    = ld_valid && ld_ready;
    assign mem_wdata = mem_we ? ld_data : 8'h00;
    assign mem_addr  = mem_we ? ld_addr : pc;
`else
    assign mem_addr  = pc;
`endif

endmodule
